// File: rtl/serial_addsub_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
// The master issues requests; the slave (the adder) returns results.
interface serial_addsub_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell time-shared over WIDTH cycles, LSB first.
// Subtraction uses a - b - cin = a + ~b + ~cin, so the cell itself never changes.
module serial_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  serial_addsub_if.slave io_bus
);
  localparam int unsigned KW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sr;
  logic             r_c;
  logic [KW-1:0]    r_k;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_s_bit;
  logic             w_c_next;
  logic             w_last;
  logic [WIDTH-1:0] w_sr_next;

  assign w_s_bit   = r_sa[0] ^ r_sb[0] ^ r_c;
  assign w_c_next  = (r_sa[0] & r_sb[0]) | (r_sa[0] & r_c) | (r_sb[0] & r_c);
  assign w_last    = (r_k == KW'(WIDTH - 1));
  assign w_sr_next = {w_s_bit, r_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_sa    <= '0;
      r_sb    <= '0;
      r_sr    <= '0;
      r_c     <= 1'b0;
      r_k     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          r_done <= 1'b0;
          if (io_bus.start) begin
            r_sa    <= io_bus.a;
            r_sb    <= io_bus.sub ? ~io_bus.b : io_bus.b;
            r_c     <= io_bus.cin ^ io_bus.sub;
            r_k     <= '0;
            r_busy  <= 1'b1;
            r_state <= StRun;
          end else begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        StRun: begin
          r_sa <= {1'b0, r_sa[WIDTH-1:1]};
          r_sb <= {1'b0, r_sb[WIDTH-1:1]};
          r_sr <= w_sr_next;
          r_c  <= w_c_next;
          r_k  <= r_k + KW'(1);
          if (w_last) begin
            r_sum   <= w_sr_next;
            r_cout  <= w_c_next;
            // Carry into the MSB differs from carry out of it exactly on signed overflow.
            r_ovf   <= r_c ^ w_c_next;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StDone;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign io_bus.busy = r_busy;
  assign io_bus.done = r_done;
  assign io_bus.sum  = r_sum;
  assign io_bus.cout = r_cout;
  assign io_bus.ovf  = r_ovf;
endmodule

// File: tb/tb_serial_addsub.sv
// Directed and model-checked bench for serial_addsub at WIDTH=8 and WIDTH=2.
module tb_serial_addsub;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  serial_addsub_if #(.WIDTH(8)) bus8 ();
  serial_addsub_if #(.WIDTH(2)) bus2 ();

  serial_addsub #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .io_bus(bus8));
  serial_addsub #(.WIDTH(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .io_bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int w, input logic st, input logic s, input logic [7:0] a,
                       input logic [7:0] b, input logic c);
    if (w == 2) begin
      bus2.start = st; bus2.sub = s; bus2.a = a[1:0]; bus2.b = b[1:0]; bus2.cin = c;
    end else begin
      bus8.start = st; bus8.sub = s; bus8.a = a; bus8.b = b; bus8.cin = c;
    end
  endtask

  function automatic void sample(input int w, output logic [7:0] sm, output logic bz,
                                 output logic dn, output logic co, output logic ov);
    if (w == 2) begin
      sm = {6'd0, bus2.sum}; bz = bus2.busy; dn = bus2.done; co = bus2.cout; ov = bus2.ovf;
    end else begin
      sm = bus8.sum; bz = bus8.busy; dn = bus8.done; co = bus8.cout; ov = bus8.ovf;
    end
  endfunction

  // Arithmetic reference: unsigned result/carry and signed range test for overflow.
  function automatic void model(input int w, input logic s, input int a, input int b,
                                input int c, output logic [7:0] sm, output logic co,
                                output logic ov);
    int mask, sa, sb, r, sr;
    mask = (1 << w) - 1;
    sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    if (!s) begin
      r  = a + b + c;
      co = (r > mask);
      sr = sa + sb + c;
    end else begin
      r  = a - b - c;
      co = (a >= b + c);
      sr = sa - sb - c;
    end
    sm = 8'(r & mask);
    ov = (sr > (1 << (w - 1)) - 1) || (sr < -(1 << (w - 1)));
  endfunction

  // Waits (bounded) for done after the accept sample; returns edges elapsed and busy samples.
  task automatic wait_done(input int w, output int lat, output int nbusy);
    logic [7:0] sm;
    logic bz, dn, co, ov;
    lat = 0; nbusy = 0;
    sample(w, sm, bz, dn, co, ov);
    while (!dn && lat < 40) begin
      if (bz) nbusy++;
      @(posedge clk); #1;
      lat++;
      sample(w, sm, bz, dn, co, ov);
    end
  endtask

  task automatic run_op(input int w, input logic s, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [7:0] es, input logic eco, input logic eov,
                        input string tag);
    logic [7:0] sm;
    logic bz, dn, co, ov;
    int lat, nbusy;
    @(negedge clk);
    drive(w, 1'b1, s, a, b, c);
    @(posedge clk); #1;
    drive(w, 1'b0, ~s, ~a, ~b, ~c);  // post-accept operand changes must be ignored
    wait_done(w, lat, nbusy);
    sample(w, sm, bz, dn, co, ov);
    check_eq({tag, "_lat"}, lat, w);
    check_eq({tag, "_busycyc"}, nbusy, w);
    check_eq({tag, "_busy_at_done"}, int'(bz), 0);
    check_eq({tag, "_sum"}, int'(sm), int'(es));
    check_eq({tag, "_cout"}, int'(co), int'(eco));
    check_eq({tag, "_ovf"}, int'(ov), int'(eov));
    @(posedge clk); #1;
    sample(w, sm, bz, dn, co, ov);
    check_eq({tag, "_done_width"}, int'(dn), 0);
  endtask

  initial begin
    logic [7:0] sm, es, ra, rb;
    logic bz, dn, co, ov, eco, eov, rs, rc;
    int lat, nbusy, ndone;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    drive(8, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    drive(2, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    sample(8, sm, bz, dn, co, ov);
    check_eq("rst_busy", int'(bz), 0);
    check_eq("rst_done", int'(dn), 0);
    check_eq("rst_sum", int'(sm), 0);
    check_eq("rst_cout_ovf", int'({co, ov}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8, 1'b0, 8'd100, 8'd27, 1'b0, 8'd127, 1'b0, 1'b0, "add_100_27");
    run_op(8, 1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, "add_ff_01_c");
    run_op(8, 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_01");
    run_op(8, 1'b1, 8'h50, 8'h70, 1'b0, 8'hE0, 1'b0, 1'b0, "sub_50_70");
    run_op(8, 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, "sub_80_01");

    // start pulsed in RUN cycles 3 and 5 with different operands is ignored
    @(negedge clk);
    drive(8, 1'b1, 1'b0, 8'd100, 8'd27, 1'b0);
    @(posedge clk); #1;
    drive(8, 1'b0, 1'b0, 8'd100, 8'd27, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    drive(8, 1'b1, 1'b1, 8'hAA, 8'h55, 1'b1);
    @(posedge clk); #1;
    drive(8, 1'b0, 1'b1, 8'hAA, 8'h55, 1'b1);
    @(posedge clk); #1;
    drive(8, 1'b1, 1'b0, 8'h11, 8'h22, 1'b1);
    @(posedge clk); #1;
    drive(8, 1'b0, 1'b0, 8'h11, 8'h22, 1'b1);
    wait_done(8, lat, nbusy);
    sample(8, sm, bz, dn, co, ov);
    check_eq("ign_lat", lat + 5, 8);
    check_eq("ign_sum", int'(sm), 127);
    check_eq("ign_cout_ovf", int'({co, ov}), 0);
    @(posedge clk); #1;
    sample(8, sm, bz, dn, co, ov);
    check_eq("ign_no_requeue", int'({bz, dn}), 0);

    // start held through DONE: back-to-back with a single non-busy cycle
    @(negedge clk);
    drive(8, 1'b1, 1'b0, 8'hFF, 8'h01, 1'b1);
    @(posedge clk); #1;
    drive(8, 1'b1, 1'b1, 8'h80, 8'h01, 1'b0);
    wait_done(8, lat, nbusy);
    sample(8, sm, bz, dn, co, ov);
    check_eq("b2b1_lat", lat, 8);
    check_eq("b2b1_busy", int'(bz), 0);
    check_eq("b2b1_sum", int'(sm), 8'h01);
    check_eq("b2b1_cout_ovf", int'({co, ov}), 2);
    @(posedge clk); #1;
    drive(8, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    sample(8, sm, bz, dn, co, ov);
    check_eq("b2b_gap_busy", int'(bz), 1);
    check_eq("b2b_gap_done", int'(dn), 0);
    wait_done(8, lat, nbusy);
    sample(8, sm, bz, dn, co, ov);
    check_eq("b2b2_lat", lat, 8);
    check_eq("b2b2_sum", int'(sm), 8'h7F);
    check_eq("b2b2_cout_ovf", int'({co, ov}), 3);
    @(posedge clk); #1;

    // asynchronous reset after 3 bits of a run
    @(negedge clk);
    drive(8, 1'b1, 1'b0, 8'h12, 8'h34, 1'b0);
    @(posedge clk); #1;
    drive(8, 1'b0, 1'b0, 8'h12, 8'h34, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sample(8, sm, bz, dn, co, ov);
    check_eq("mid_rst_busy", int'(bz), 0);
    check_eq("mid_rst_done", int'(dn), 0);
    check_eq("mid_rst_sum", int'(sm), 0);
    check_eq("mid_rst_cout_ovf", int'({co, ov}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      sample(8, sm, bz, dn, co, ov);
      if (dn || bz) ndone++;
    end
    check_eq("mid_rst_no_done", ndone, 0);
    run_op(8, 1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, "post_rst_add");

    // exhaustive at WIDTH=2
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < 2; c++) begin
        for (int a = 0; a < 4; a++) begin
          for (int b = 0; b < 4; b++) begin
            model(2, s[0], a, b, c, es, eco, eov);
            run_op(2, s[0], 8'(a), 8'(b), c[0], es, eco, eov, "w2");
          end
        end
      end
    end

    // random at WIDTH=8
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      model(8, rs, int'(ra), int'(rb), int'(rc), es, eco, eov);
      run_op(8, rs, ra, rb, rc, es, eco, eov, "w8_rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
